// File: rtl/vram_arbiter_if.sv
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : Bundle of the video, CPU and VRAM-macro signals around vram_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 18
);
  logic          PCLK_EN;
  logic          BLANK;
  logic [AW-1:0] VID_ADDR;
  logic [DW-1:0] VID_DATA;
  logic          VID_VALID;

  logic          CPU_REQ;
  logic          CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_ACK;
  logic [DW-1:0] CPU_RDATA;

  logic [AW-1:0] MEM_ADDR;
  logic          MEM_WE;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;

  logic [15:0]   STALL_CNT;

  // Arbiter side
  modport slave (
    input  PCLK_EN, BLANK, VID_ADDR,
    input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  MEM_RDATA,
    output VID_DATA, VID_VALID,
    output CPU_ACK, CPU_RDATA,
    output MEM_ADDR, MEM_WE, MEM_WDATA,
    output STALL_CNT
  );

  // Timing generator / CPU / VRAM side
  modport master (
    output PCLK_EN, BLANK, VID_ADDR,
    output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output MEM_RDATA,
    input  VID_DATA, VID_VALID,
    input  CPU_ACK, CPU_RDATA,
    input  MEM_ADDR, MEM_WE, MEM_WDATA,
    input  STALL_CNT
  );
endinterface

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM arbiter; fixed-latency video reads win, CPU uses
//            req/ack in the free slots. Optional macro ARB_STALL_CNT_EN adds a
//            saturating CPU deferral counter on STALL_CNT.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vram_arbiter #(
  parameter int AW = 16,
  parameter int DW = 18
) (
  input  logic           CLK50M,
  input  logic           RESET,
  vram_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]    state_q, state_d;

  logic          defer_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;

  logic          vid_iss_q;
  logic          vid_rd_q;
  logic          vid_valid_q;
  logic [DW-1:0] vid_data_q;
  logic [DW-1:0] cpu_rdata_q;

  logic          vid_hit;
  logic          cpu_accept;
  logic          cpu_go;
  logic          cpu_stall;
  logic          cpu_ack;
  logic          cpu_we_sel;
  logic [AW-1:0] cpu_addr_sel;
  logic [DW-1:0] cpu_wdata_sel;

  assign vid_hit = bus.PCLK_EN && !bus.BLANK;

  // A deferred request issues from the latched copy; a fresh one straight from the port
  assign cpu_we_sel    = defer_q ? we_q    : bus.CPU_WE;
  assign cpu_addr_sel  = defer_q ? addr_q  : bus.CPU_ADDR;
  assign cpu_wdata_sel = defer_q ? wdata_q : bus.CPU_WDATA;

  always_ff @(posedge CLK50M) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cpu_go) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_accept = 1'b0;
    cpu_go     = 1'b0;
    cpu_stall  = 1'b0;
    cpu_ack    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_accept = bus.CPU_REQ && !defer_q;
        cpu_go     = (bus.CPU_REQ || defer_q) && !vid_hit;
        cpu_stall  = (bus.CPU_REQ || defer_q) && vid_hit;
      end
      S_ACK:   cpu_ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      defer_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vid_iss_q   <= 1'b0;
      vid_rd_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (cpu_accept) begin
        we_q    <= bus.CPU_WE;
        addr_q  <= bus.CPU_ADDR;
        wdata_q <= bus.CPU_WDATA;
      end
      defer_q <= cpu_stall;

      mem_we_q <= 1'b0;
      if (vid_hit) begin
        mem_addr_q <= bus.VID_ADDR;
      end else if (cpu_go) begin
        mem_addr_q <= cpu_addr_sel;
        mem_we_q   <= cpu_we_sel;
        if (cpu_we_sel) mem_wdata_q <= cpu_wdata_sel;
      end

      // Video read pipe: issue, RAM latency, capture
      vid_iss_q   <= vid_hit;
      vid_rd_q    <= vid_iss_q;
      vid_valid_q <= vid_rd_q;
      if (vid_rd_q) vid_data_q <= bus.MEM_RDATA;

      if (state_q == S_WAIT && !we_q) cpu_rdata_q <= bus.MEM_RDATA;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge CLK50M) begin
    if (RESET)                                   stall_cnt_q <= 16'd0;
    else if (cpu_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign bus.STALL_CNT = stall_cnt_q;
`else
  assign bus.STALL_CNT = 16'd0;
`endif

  assign bus.MEM_ADDR  = mem_addr_q;
  assign bus.MEM_WE    = mem_we_q;
  assign bus.MEM_WDATA = mem_wdata_q;
  assign bus.VID_DATA  = vid_data_q;
  assign bus.VID_VALID = vid_valid_q;
  assign bus.CPU_ACK   = cpu_ack;
  assign bus.CPU_RDATA = cpu_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Scoreboard bench for vram_arbiter with a behavioural VRAM model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vram_arbiter;
  localparam int AW = 16;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  vram_arbiter #(.AW(AW), .DW(DW)) dut (.CLK50M(clk), .RESET(rst), .bus(bus));

  typedef struct { int cyc; logic [17:0] data; } vid_exp_t;
  typedef struct { int cyc; logic [15:0] addr; logic we; logic [17:0] wdata; } iss_exp_t;
  typedef struct { int cyc; logic rd; logic [17:0] data; } cpu_exp_t;

  vid_exp_t vq[$];
  iss_exp_t iq[$];
  cpu_exp_t cq[$];

  logic [17:0] wmem [int];

  function automatic logic [17:0] pattern(input logic [15:0] a);
    if (a == 16'h0123) return 18'h3ABCD;
    return {2'b10, a} ^ 18'h05A5A;
  endfunction

  // VRAM model: one-cycle read latency, write on MEM_WE
  always @(posedge clk) begin
    bus.MEM_RDATA <= wmem.exists(int'(bus.MEM_ADDR)) ? wmem[int'(bus.MEM_ADDR)] : pattern(bus.MEM_ADDR);
    if (bus.MEM_WE) wmem[int'(bus.MEM_ADDR)] = bus.MEM_WDATA;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit e;
      e = (vq.size() > 0) && (vq[0].cyc == cyc);
      if (bus.VID_VALID || e) begin
        check_val("vid_valid", {31'd0, bus.VID_VALID}, {31'd0, e});
        if (e) begin
          check_val("vid_data", {14'd0, bus.VID_DATA}, {14'd0, vq[0].data});
          void'(vq.pop_front());
        end
      end
      e = (iq.size() > 0) && (iq[0].cyc == cyc);
      if (e) begin
        check_val("mem_addr", {16'd0, bus.MEM_ADDR}, {16'd0, iq[0].addr});
        check_val("mem_we", {31'd0, bus.MEM_WE}, {31'd0, iq[0].we});
        if (iq[0].we) check_val("mem_wdata", {14'd0, bus.MEM_WDATA}, {14'd0, iq[0].wdata});
        void'(iq.pop_front());
      end else if (bus.MEM_WE) begin
        check_val("mem_we_spurious", {31'd0, bus.MEM_WE}, 32'd0);
      end
      e = (cq.size() > 0) && (cq[0].cyc == cyc);
      if (bus.CPU_ACK || e) begin
        check_val("cpu_ack", {31'd0, bus.CPU_ACK}, {31'd0, e});
        if (e) begin
          if (cq[0].rd) check_val("cpu_rdata", {14'd0, bus.CPU_RDATA}, {14'd0, cq[0].data});
          void'(cq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vid_fetch(input logic [15:0] a);
    bus.PCLK_EN  = 1'b1;
    bus.BLANK    = 1'b0;
    bus.VID_ADDR = a;
    iq.push_back('{cyc + 1, a, 1'b0, 18'd0});
    vq.push_back('{cyc + 3, pattern(a)});
    tick();
    bus.PCLK_EN = 1'b0;
    repeat (7) tick();
  endtask

  // One CPU transaction, optionally with a pixel strobe in the request cycle
  task automatic cpu_txn(input logic we, input logic [15:0] a, input logic [17:0] wd,
                         input logic [17:0] rd_exp, input logic strobe, input logic blank,
                         input logic [15:0] va);
    int c;
    int d;
    c = cyc;
    d = (strobe && !blank) ? 1 : 0;
    bus.CPU_REQ   = 1'b1;
    bus.CPU_WE    = we;
    bus.CPU_ADDR  = a;
    bus.CPU_WDATA = wd;
    bus.PCLK_EN   = strobe;
    bus.BLANK     = blank;
    bus.VID_ADDR  = va;
    if (d == 1) begin
      iq.push_back('{c + 1, va, 1'b0, 18'd0});
      vq.push_back('{c + 3, pattern(va)});
    end
    iq.push_back('{c + 1 + d, a, we, wd});
    cq.push_back('{c + 3 + d, !we, rd_exp});
    tick();
    bus.PCLK_EN   = 1'b0;
    bus.BLANK     = 1'b0;
    // Fields are latched at acceptance; later changes must not leak through
    bus.CPU_ADDR  = 16'($urandom);
    bus.CPU_WDATA = 18'($urandom);
    bus.CPU_WE    = 1'($urandom);
    repeat (2 + d) tick();
    tick();
    bus.CPU_REQ = 1'b0;
    tick();
  endtask

  logic [15:0] exp_stall;
  int          c0;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.PCLK_EN   = 1'($urandom);
      bus.BLANK     = 1'($urandom);
      bus.VID_ADDR  = 16'($urandom);
      bus.CPU_REQ   = 1'($urandom);
      bus.CPU_WE    = 1'($urandom);
      bus.CPU_ADDR  = 16'($urandom);
      bus.CPU_WDATA = 18'($urandom);
      tick();
    end
    rst = 1'b0;
    bus.PCLK_EN = 1'b0; bus.BLANK = 1'b0; bus.VID_ADDR = '0;
    bus.CPU_REQ = 1'b0; bus.CPU_WE = 1'b0; bus.CPU_ADDR = '0; bus.CPU_WDATA = '0;
    mon_en = 1'b1;
    @(negedge clk);
    check_val("rst_vid_data",  {14'd0, bus.VID_DATA}, 32'd0);
    check_val("rst_vid_valid", {31'd0, bus.VID_VALID}, 32'd0);
    check_val("rst_cpu_ack",   {31'd0, bus.CPU_ACK}, 32'd0);
    check_val("rst_cpu_rdata", {14'd0, bus.CPU_RDATA}, 32'd0);
    check_val("rst_mem_addr",  {16'd0, bus.MEM_ADDR}, 32'd0);
    check_val("rst_mem_we",    {31'd0, bus.MEM_WE}, 32'd0);
    check_val("rst_mem_wdata", {14'd0, bus.MEM_WDATA}, 32'd0);
    check_val("rst_stall_cnt", {16'd0, bus.STALL_CNT}, 32'd0);
    tick();

    // Video fetches
    vid_fetch(16'h0123);
    vid_fetch(16'h0456);

    // CPU write/read, no collision
    cpu_txn(1'b1, 16'h0040, 18'h15555, 18'h0, 1'b0, 1'b0, 16'h0);
    cpu_txn(1'b0, 16'h0040, 18'h0,     18'h15555, 1'b0, 1'b0, 16'h0);
    cpu_txn(1'b1, 16'h1234, 18'h2AAAA, 18'h0, 1'b0, 1'b0, 16'h0);
    cpu_txn(1'b0, 16'h1234, 18'h0,     18'h2AAAA, 1'b0, 1'b0, 16'h0);

    // Collisions: read, then write, each against a pixel strobe
    cpu_txn(1'b0, 16'h0040, 18'h0, 18'h15555, 1'b1, 1'b0, 16'h0123);
`ifdef ARB_STALL_CNT_EN
    exp_stall = 16'd1;
`else
    exp_stall = 16'd0;
`endif
    check_val("stall_cnt_1", {16'd0, bus.STALL_CNT}, {16'd0, exp_stall});
    cpu_txn(1'b1, 16'h0077, 18'h0F0F0, 18'h0, 1'b1, 1'b0, 16'h0456);
`ifdef ARB_STALL_CNT_EN
    exp_stall = 16'd2;
`endif
    check_val("stall_cnt_2", {16'd0, bus.STALL_CNT}, {16'd0, exp_stall});
    cpu_txn(1'b0, 16'h0077, 18'h0, 18'h0F0F0, 1'b0, 1'b0, 16'h0);

    // Blanking: strobes make no fetch, VID_DATA holds the last fetched word
    for (int i = 0; i < 4; i++) begin
      bus.PCLK_EN  = 1'b1;
      bus.BLANK    = 1'b1;
      bus.VID_ADDR = 16'h0200 + 16'(i);
      tick();
      bus.PCLK_EN = 1'b0;
      repeat (7) tick();
    end
    check_val("blank_vid_hold", {14'd0, bus.VID_DATA}, {14'd0, pattern(16'h0456)});
    cpu_txn(1'b0, 16'h0040, 18'h0, 18'h15555, 1'b1, 1'b1, 16'h0300);
    bus.BLANK = 1'b0;

    // Reset while the CPU read sits in WAIT
    c0 = cyc;
    bus.CPU_REQ  = 1'b1;
    bus.CPU_WE   = 1'b0;
    bus.CPU_ADDR = 16'h0040;
    iq.push_back('{c0 + 1, 16'h0040, 1'b0, 18'd0});
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.CPU_REQ = 1'b0;
    @(negedge clk);
    check_val("rst_mid_no_ack", {31'd0, bus.CPU_ACK}, 32'd0);
    check_val("rst_mid_stall",  {16'd0, bus.STALL_CNT}, 32'd0);
    tick();
    tick();
    cpu_txn(1'b0, 16'h1234, 18'h0, 18'h2AAAA, 1'b0, 1'b0, 16'h0);
    vid_fetch(16'h0789);

    repeat (4) tick();
    check_val("scoreboard_drained", vq.size() + iq.size() + cq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters: the pixel scan-out path and a CPU/loader port.
- Runs on the 50 MHz system clock. A one-cycle pixel strobe arrives every 8 cycles, matching the divide-by-8 pixel clock.
- Video reads have fixed priority and deterministic latency. CPU accesses use a req/ack handshake in the remaining slots.
- Sits between the timing generator, the colour output stage and the VRAM macro.

Parameters:
- AW, 16, address width of VRAM and of both requester ports.
- DW, 18, data width (18-bit colour words).

Ports:
- CLK50M  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- PCLK_EN  in  1  one-cycle pixel strobe, minimum spacing 4 cycles.
- BLANK  in  1  HBLK|VBLK; when high, no video fetch is made.
- VID_ADDR  in  AW  pixel address, sampled on PCLK_EN.
- VID_DATA  out  DW  fetched pixel word.
- VID_VALID  out  1  one-cycle pulse when VID_DATA updates.
- CPU_REQ  in  1  access request.
- CPU_WE  in  1  1 = write, 0 = read.
- CPU_ADDR  in  AW  CPU address.
- CPU_WDATA  in  DW  CPU write data.
- CPU_ACK  out  1  one-cycle completion pulse.
- CPU_RDATA  out  DW  read data, valid while CPU_ACK is high.
- MEM_ADDR  out  AW  VRAM address, registered.
- MEM_WE  out  1  VRAM write enable, registered.
- MEM_WDATA  out  DW  VRAM write data, registered.
- MEM_RDATA  in  DW  VRAM read data, valid 1 cycle after its issue cycle.
- STALL_CNT  out  16  CPU deferral counter (see Optional Feature).

Behaviour:
- Reset: all outputs are 0, the CPU FSM goes to IDLE, and the video-pending flag clears.
  - Reset mid-access abandons the access: no ACK and no VALID pulse.
  - MEM_WE is forced to 0 in the cycle after RESET is sampled.
- Issue cycle: the cycle in which MEM_* carry an access.
  - MEM_WE=1 only in a CPU write issue cycle.
  - MEM_ADDR and MEM_WDATA otherwise hold their last value.
- Video path:
  - PCLK_EN=1 and BLANK=0 at cycle t captures VID_ADDR.
  - Issue read at t+1.
  - Register MEM_RDATA into VID_DATA at the end of t+2.
  - VID_VALID=1 during t+3 only.
  - Latency is fixed at 3 cycles, independent of CPU activity.
  - With BLANK=1 at the strobe: no issue, no VALID, and VID_DATA holds.
- CPU FSM states: IDLE, ISSUE, WAIT, ACK.
  - IDLE: if CPU_REQ=1 at cycle c, latch WE/ADDR/WDATA.
    - If no video issue is due at c+1 (i.e. no qualifying PCLK_EN at c), go to ISSUE and issue at c+1.
    - Otherwise stay deferred one cycle and issue at c+2. The deferral is counted as one stall.
  - ISSUE: drive MEM_* from the latched fields, then go to WAIT.
  - WAIT: capture MEM_RDATA into CPU_RDATA (reads only; writes leave CPU_RDATA unchanged), then go to ACK.
  - ACK: CPU_ACK=1 for one cycle, then go to IDLE. CPU_REQ sampled during ACK is ignored.
  - Uncontended ACK is at c+3 after request. With a video collision, ACK is at c+4.
- Priority and collisions:
  - Video always wins an issue slot.
  - At most one access is issued per cycle.
  - With PCLK_EN spacing of at least 4, the CPU is deferred at most 1 cycle per transaction.
- Handshake:
  - The requester holds CPU_REQ, WE, ADDR and WDATA stable until ACK.
  - Fields are latched at acceptance; changes after the IDLE sample are ignored.
  - Back-to-back: CPU_REQ held high gives a new transaction accepted in the IDLE cycle after ACK, i.e. one access per 4 cycles.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- Defined: STALL_CNT is a 16-bit counter that increments once per cycle a latched CPU request is deferred by a video issue.
  - Saturates at 16'hFFFF.
  - Cleared only by RESET.
- Undefined: no counter logic; STALL_CNT is tied to 0. All other behaviour is identical.

Test Plan:
1. Reset:
   - Assert RESET 2 cycles with random inputs -> all outputs 0, MEM_WE=0.
   - Then the first PCLK_EN with BLANK=0 -> normal 3-cycle video fetch.
2. Video fetch:
   - PCLK_EN at t, VID_ADDR=16'h0123, model returns 18'h3ABCD -> MEM_ADDR=16'h0123 at t+1.
   - VID_DATA=18'h3ABCD and VID_VALID=1 at t+3 only.
3. CPU write then read, no collision:
   - Write REQ at c, ADDR=16'h0040, WDATA=18'h15555 -> MEM_WE=1 at c+1, ACK at c+3.
   - Read of 16'h0040 -> CPU_RDATA=18'h15555 with ACK.
4. Collision:
   - CPU_REQ and PCLK_EN both at cycle c -> video issue at c+1, CPU issue at c+2, CPU_ACK at c+4.
   - VID_VALID still at c+3.
   - STALL_CNT=1 with ARB_STALL_CNT_EN, 0 without.
5. Blanking:
   - BLANK=1 across 4 strobes -> no video issue, no VID_VALID, VID_DATA unchanged.
   - CPU reads are unaffected.
6. Reset mid-read:
   - RESET in the WAIT state -> no CPU_ACK.
   - FSM returns to IDLE, and a new request completes normally with ACK at c+3.
